// File: rtl/imm_encoder.sv
// RV32I instruction assembler: packs format/register fields and a 32-bit immediate
// into an instruction word, buffered behind a 2-entry valid/ready output FIFO.
module imm_encoder #(
  parameter bit STRICT = 1'b1,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       immsrc,
  input  logic [6:0]       opcode,
  input  logic [4:0]       rd,
  input  logic [4:0]       rs1,
  input  logic [4:0]       rs2,
  input  logic [2:0]       funct3,
  input  logic [6:0]       funct7,
  input  logic [31:0]      imm,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_instr,
  output logic             out_err,
  output logic [CNT_W-1:0] enc_count,
  output logic [CNT_W-1:0] err_count,
  output logic             err_sticky
);

  localparam logic [2:0] FMT_I = 3'b000;
  localparam logic [2:0] FMT_S = 3'b001;
  localparam logic [2:0] FMT_B = 3'b010;
  localparam logic [2:0] FMT_J = 3'b011;
  localparam logic [2:0] FMT_U = 3'b100;
  localparam logic [2:0] FMT_R = 3'b111;

  // Returns {legal, word}; an illegal immediate still yields the truncated word.
  function automatic logic [32:0] encode(
    input logic [2:0]  fmt,
    input logic [6:0]  op,
    input logic [4:0]  f_rd,
    input logic [4:0]  f_rs1,
    input logic [4:0]  f_rs2,
    input logic [2:0]  f3,
    input logic [6:0]  f7,
    input logic [31:0] v
  );
    logic        legal;
    logic [31:0] word;
    legal = 1'b0;
    word  = 32'd0;
    case (fmt)
      FMT_I: begin
        word  = {v[11:0], f_rs1, f3, f_rd, op};
        legal = (v[31:11] == {21{v[11]}});
      end
      FMT_S: begin
        word  = {v[11:5], f_rs2, f_rs1, f3, v[4:0], op};
        legal = (v[31:11] == {21{v[11]}});
      end
      FMT_B: begin
        word  = {v[12], v[10:5], f_rs2, f_rs1, f3, v[4:1], v[11], op};
        legal = (v[0] == 1'b0) && (v[31:12] == {20{v[12]}});
      end
      FMT_J: begin
        word  = {v[20], v[10:1], v[11], v[19:12], f_rd, op};
        legal = (v[0] == 1'b0) && (v[31:20] == {12{v[20]}});
      end
      FMT_U: begin
        word  = {v[31:12], f_rd, op};
        legal = (v[11:0] == 12'd0);
      end
      FMT_R: begin
        word  = {f7, f_rs2, f_rs1, f3, f_rd, op};
        legal = 1'b1;
      end
      default: begin
        word  = 32'd0;
        legal = 1'b0;
      end
    endcase
    return {legal, word};
  endfunction

  logic [32:0] enc;
  logic        enc_legal;
  logic [31:0] enc_word;
  logic [1:0]  count;
  logic [31:0] word0, word1;
  logic        err0, err1;
  logic        ready_en;
  logic        take, push, pop;

  // Combinational encode of the presented beat.
  always_comb begin
    enc       = encode(immsrc, opcode, rd, rs1, rs2, funct3, funct7, imm);
    enc_legal = enc[32];
    enc_word  = enc[31:0];
  end

  // ready_en holds in_ready low until the first edge after reset release.
  assign in_ready  = ready_en && (count != 2'd2);
  assign out_valid = (count != 2'd0);
  assign out_instr = word0;
  assign out_err   = err0;
  assign take      = in_valid && in_ready;
  assign push      = take && (enc_legal || !STRICT);
  assign pop       = out_valid && out_ready;

  // FIFO storage, occupancy and status counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_en   <= 1'b0;
      count      <= 2'd0;
      word0      <= 32'd0;
      word1      <= 32'd0;
      err0       <= 1'b0;
      err1       <= 1'b0;
      enc_count  <= '0;
      err_count  <= '0;
      err_sticky <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            word0 <= enc_word;
            err0  <= !enc_legal;
          end else begin
            word1 <= enc_word;
            err1  <= !enc_legal;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          word0 <= word1;
          err0  <= err1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // Push can only coincide with pop at occupancy 1: new beat becomes head.
          word0 <= enc_word;
          err0  <= !enc_legal;
        end
        default: begin
          count <= count;
        end
      endcase
      if (take) begin
        enc_count <= enc_count + {{(CNT_W-1){1'b0}}, 1'b1};
        if (!enc_legal) begin
          err_count  <= err_count + {{(CNT_W-1){1'b0}}, 1'b1};
          err_sticky <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Scoreboard bench for imm_encoder: directed vectors plus a round-trip sweep through
// an independent immediate extender; a second STRICT=0 instance covers err forwarding.
module tb_imm_encoder;
  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_valid0, in_ready, in_ready0;
  logic [2:0]  immsrc;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;
  logic        out_valid, out_ready, out_err;
  logic [31:0] out_instr;
  logic [15:0] enc_count, err_count;
  logic        err_sticky;
  logic        out_valid0, out_err0, err_sticky0;
  logic [31:0] out_instr0;
  logic [15:0] enc_count0, err_count0;

  typedef struct {
    logic        rt;
    logic [31:0] word;
    logic        err;
    logic [2:0]  fmt;
    logic [31:0] imm;
    logic [6:0]  op;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  int checks = 0;
  int failures = 0;
  int exp_enc = 0;
  int exp_err = 0;

  always #5 clk = ~clk;

  imm_encoder #(.STRICT(1'b1), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .immsrc(immsrc), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_err(out_err),
    .enc_count(enc_count), .err_count(err_count), .err_sticky(err_sticky)
  );

  imm_encoder #(.STRICT(1'b0), .CNT_W(16)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid0), .in_ready(in_ready0),
    .immsrc(immsrc), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid0), .out_ready(1'b1), .out_instr(out_instr0), .out_err(out_err0),
    .enc_count(enc_count0), .err_count(err_count0), .err_sticky(err_sticky0)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Pipeline immediate extender, used to recover imm from the emitted word.
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [2:0] fmt);
    case (fmt)
      3'b000:  return {{20{w[31]}}, w[31:20]};
      3'b001:  return {{20{w[31]}}, w[31:25], w[11:7]};
      3'b010:  return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
      3'b011:  return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
      3'b100:  return {w[31:12], 12'd0};
      default: return 32'd0;
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (q1.size() == 0) begin
        chk("unexpected_out", out_instr, 32'd0);
      end else begin
        e = q1.pop_front();
        if (e.rt) begin
          chk("roundtrip_imm", extend(out_instr, e.fmt), e.imm);
          chk("roundtrip_op", {25'd0, out_instr[6:0]}, {25'd0, e.op});
        end else begin
          chk("word", out_instr, e.word);
        end
        chk("err", {31'd0, out_err}, {31'd0, e.err});
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid0) begin
      if (q0.size() == 0) begin
        chk("unexpected_out0", out_instr0, 32'd0);
      end else begin
        e = q0.pop_front();
        chk("word0", out_instr0, e.word);
        chk("err0", {31'd0, out_err0}, {31'd0, e.err});
      end
    end
  end

  task automatic set_fields(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                            input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                            input logic [6:0] f7, input logic [31:0] v);
    immsrc = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = v;
  endtask

  // Drive one beat into the STRICT=1 instance; called just after a rising edge.
  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] v,
                      input logic rt, input logic [31:0] word, input logic legal);
    exp_t e;
    int n = 0;
    set_fields(f, op, d, s1, s2, f3, f7, v);
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 32'd0, 32'd1);
    e.rt = rt; e.word = word; e.err = 1'b0; e.fmt = f; e.imm = v; e.op = op;
    if (legal) q1.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    exp_enc++;
    if (!legal) exp_err++;
  endtask

  task automatic send0(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] v,
                       input logic [31:0] word, input logic err);
    exp_t e;
    set_fields(f, op, d, s1, s2, f3, f7, v);
    in_valid0 = 1'b1;
    @(negedge clk);
    if (!in_ready0) chk("ready0", 32'd0, 32'd1);
    e.rt = 1'b0; e.word = word; e.err = err; e.fmt = f; e.imm = v; e.op = op;
    q0.push_back(e);
    @(posedge clk);
    #1;
    in_valid0 = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q1.size() != 0 || q0.size() != 0) && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (q1.size() != 0 || q0.size() != 0) chk("drain_timeout", 32'd0, 32'd1);
    #1;
  endtask

  initial begin
    int base;
    logic [2:0]  f;
    logic [31:0] v;
    logic [6:0]  op;
    logic [4:0]  d, s1, s2;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [2:0]  fmts [6];
    fmts = '{3'b000, 3'b001, 3'b010, 3'b011, 3'b100, 3'b111};

    reset = 1'b1; in_valid = 1'b0; in_valid0 = 1'b0; out_ready = 1'b1;
    set_fields(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    #12;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_instr", out_instr, 32'd0);
    chk("rst_enc_count", {16'd0, enc_count}, 32'd0);
    chk("rst_err_sticky", {31'd0, err_sticky}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_release", {31'd0, in_ready}, 32'd1);

    // addi x5,x6,-1
    send(3'b000, 7'b0010011, 5'd5, 5'd6, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF3_0293, 1'b1);
    chk("i_latency_valid", {31'd0, out_valid}, 32'd1);
    chk("i_latency_word", out_instr, 32'hFFF3_0293);
    chk("i_enc_count", {16'd0, enc_count}, 32'd1);
    // beq x1,x2,+8 then jal x1,-4 back to back
    send(3'b010, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd8, 1'b0, 32'h0020_8463, 1'b1);
    send(3'b011, 7'b1101111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'hFFFF_FFFC, 1'b0, 32'hFFDF_F0EF, 1'b1);
    // sw x2,8(x1) and add x3,x1,x2
    send(3'b001, 7'b0100011, 5'd0, 5'd1, 5'd2, 3'b010, 7'd0, 32'd8, 1'b0, 32'h0020_A423, 1'b1);
    send(3'b111, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'hDEAD_BEEF, 1'b0, 32'h0020_81B3, 1'b1);
    drain();
    chk("err_sticky_clean", {31'd0, err_sticky}, 32'd0);

    // Illegal beats: odd B offset, I offset 2048, reserved format 101
    send(3'b010, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3, 1'b0, 32'd0, 1'b0);
    chk("strict_err_count1", {16'd0, err_count}, 32'd1);
    chk("strict_sticky", {31'd0, err_sticky}, 32'd1);
    send(3'b000, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'b000, 7'd0, 32'h0000_0800, 1'b0, 32'd0, 1'b0);
    send(3'b101, 7'b0010011, 5'd1, 5'd1, 5'd0, 3'b000, 7'd0, 32'd0, 1'b0, 32'd0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    chk("strict_no_output", {31'd0, out_valid}, 32'd0);
    chk("strict_err_count3", {16'd0, err_count}, 32'd3);
    chk("strict_enc_count", {16'd0, enc_count}, exp_enc);

    // Non-strict instance forwards the truncated word flagged as err
    send0(3'b010, 7'b1100011, 5'd0, 5'd1, 5'd2, 3'b000, 7'd0, 32'd3, 32'h0020_8163, 1'b1);
    send0(3'b111, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 32'h0020_81B3, 1'b0);
    send0(3'b110, 7'b0110011, 5'd3, 5'd1, 5'd2, 3'b000, 7'd0, 32'd0, 32'h0000_0000, 1'b1);
    drain();
    chk("lax_err_count", {16'd0, err_count0}, 32'd2);
    chk("lax_sticky", {31'd0, err_sticky0}, 32'd1);

    // Backpressure: three lui x1,0x12345000 with out_ready low
    out_ready = 1'b0;
    base = exp_enc;
    fork
      begin
        for (int i = 0; i < 3; i++)
          send(3'b100, 7'b0110111, 5'd1, 5'd0, 5'd0, 3'b000, 7'd0, 32'h1234_5000, 1'b0, 32'h1234_50B7, 1'b1);
      end
      begin
        repeat (5) @(negedge clk);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_enc_count", {16'd0, enc_count}, base + 2);
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("bp_enc_count_final", {16'd0, enc_count}, base + 3);

    // Asynchronous reset with two beats buffered
    out_ready = 1'b0;
    send(3'b100, 7'b0110111, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0000_1000, 1'b0, 32'h0000_1137, 1'b1);
    send(3'b100, 7'b0110111, 5'd2, 5'd0, 5'd0, 3'b000, 7'd0, 32'h0000_2000, 1'b0, 32'h0000_2137, 1'b1);
    @(negedge clk); #2;
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1;
    #1;
    chk("arst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_out_instr", out_instr, 32'd0);
    chk("arst_enc_count", {16'd0, enc_count}, 32'd0);
    chk("arst_err_count", {16'd0, err_count}, 32'd0);
    chk("arst_sticky", {31'd0, err_sticky}, 32'd0);
    chk("arst_in_ready", {31'd0, in_ready}, 32'd0);
    q1.delete();
    exp_enc = 0;
    exp_err = 0;
    #3;
    reset = 1'b0;
    #1;
    chk("released_before_edge", {31'd0, in_ready}, 32'd0);
    @(posedge clk); #1;
    chk("released_after_edge", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;

    // Round-trip sweep over the legal formats with occasional reserved-format beats
    for (int i = 0; i < 60; i++) begin
      op = 7'($urandom); d = 5'($urandom); s1 = 5'($urandom); s2 = 5'($urandom);
      f3 = 3'($urandom); f7 = 7'($urandom); v = $urandom;
      if (i % 7 == 6) begin
        send(3'b101, op, d, s1, s2, f3, f7, v, 1'b0, 32'd0, 1'b0);
      end else begin
        f = fmts[i % 6];
        case (f)
          3'b000, 3'b001: v = {{20{v[11]}}, v[11:0]};
          3'b010:         v = {{19{v[12]}}, v[12:1], 1'b0};
          3'b011:         v = {{11{v[20]}}, v[20:1], 1'b0};
          3'b100:         v = {v[31:12], 12'd0};
          default:        v = v;
        endcase
        if (f == 3'b111)
          send(f, op, d, s1, s2, f3, f7, v, 1'b0, {f7, s2, s1, f3, d, op}, 1'b1);
        else
          send(f, op, d, s1, s2, f3, f7, v, 1'b1, 32'd0, 1'b1);
      end
    end
    drain();
    chk("sweep_err_count", {16'd0, err_count}, exp_err);
    chk("sweep_enc_count", {16'd0, enc_count}, exp_enc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/imm_encoder.md
Name: imm_encoder

Overview:
- Streaming instruction assembler: takes a format select, register/function fields and a 32-bit immediate, and emits the packed 32-bit RV32I instruction word.
- It is the inverse of the pipeline's immediate extender and uses the same immsrc codes.
- Used by the boot/self-test instruction-memory loader and by the verification environment, so generated programs round-trip through the decode path.
- Valid/ready on both sides, with a 2-entry output buffer and range checking of immediates.

Parameters:
- STRICT, 1, 1: unencodable inputs are dropped and counted; 0: they are forwarded with err=1 and the immediate is truncated.
- CNT_W, 16, width of the accepted-instruction and error counters.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  encoder can accept a beat this cycle.
- immsrc  in  3  format: 000 I, 001 S, 010 B, 011 J, 100 U, 111 R; 101 and 110 are illegal.
- opcode  in  7  instr[6:0].
- rd  in  5  destination register.
- rs1  in  5  source register 1.
- rs2  in  5  source register 2.
- funct3  in  3  function field.
- funct7  in  7  used for R only.
- imm  in  32  sign-extended byte-offset immediate (U: full upper value).
- out_valid  out  1  out_instr is valid.
- out_ready  in  1  downstream accepts.
- out_instr  out  32  encoded instruction.
- out_err  out  1  beat was unencodable (only possible when STRICT=0).
- enc_count  out  CNT_W  beats accepted on the input.
- err_count  out  CNT_W  unencodable beats seen.
- err_sticky  out  1  set on the first unencodable beat; cleared only by reset.

Behaviour:
- Handshake: an input transfer occurs when in_valid && in_ready; an output transfer when out_valid && out_ready. Payload must be held stable while in_valid && !in_ready.
- Encoding is combinational on the accepted beat and written into a 2-entry FIFO (word + err bit).
- Latency is 1 cycle: a beat accepted at edge N is visible on out_instr after edge N when the FIFO was empty.
- in_ready = (FIFO occupancy < 2), taken from registered occupancy only, with no combinational path from out_ready.
  - Occupancy 2 with a simultaneous pop: in_ready stays 0 this cycle.
  - Occupancy 1 with simultaneous push and pop: occupancy stays 1 and order is preserved.
- Full throughput: 1 beat/cycle when out_ready is held high.
- Bit layout and legality:
  - I: {imm[11:0],rs1,funct3,rd,opcode}. Legal iff imm[31:11] all equal.
  - S: {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}. Legal iff imm[31:11] all equal.
  - B: {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}. Legal iff imm[0]=0 and imm[31:12] all equal.
  - J: {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}. Legal iff imm[0]=0 and imm[31:20] all equal.
  - U: {imm[31:12],rd,opcode}. Legal iff imm[11:0]=0.
  - R: {funct7,rs2,rs1,funct3,rd,opcode}. Always legal; imm is ignored.
  - 101/110: always illegal; the word is encoded as all zeros.
- Illegal beat:
  - Always accepted (never stalls).
  - enc_count and err_count both increment; err_sticky is set.
  - STRICT=1: nothing is pushed.
  - STRICT=0: the truncated word is pushed with err=1.
- Counters wrap modulo 2^CNT_W with no saturation.
- Reset (asynchronous, any time including mid-stream): FIFO emptied, out_valid=0, out_instr=0, out_err=0, enc_count=0, err_count=0, err_sticky=0.
  - in_ready reads 0 while reset is asserted and becomes 1 on the first clock edge after release.
  - In-flight beats are lost.
- Round-trip invariant: for every output with out_err=0 (format ≠ R), passing the word through the immediate extender with the same immsrc returns exactly imm.

Test Plan:
- I-type addi x5,x6,-1 (opcode 0010011, funct3 000, imm 0xFFFFFFFF), out_ready=1 -> after 1 cycle out_instr=0xFFF30293, out_err=0, enc_count=1.
- B-type beq x1,x2,+8 (opcode 1100011, imm 8), then J-type jal x1,-4 (opcode 1101111, imm 0xFFFFFFFC) back-to-back -> 0x00208463 then 0xFFDFF0EF on consecutive cycles.
- STRICT=1, B-type imm=3 -> no output beat, err_count=1, err_sticky=1; rerun with STRICT=0 -> output beat with out_err=1.
- Backpressure: out_ready=0, 3 back-to-back U-type beats (lui x1,0x12345000) -> in_ready drops after 2 accepts. Raise out_ready -> the three words 0x123450B7 emerge in order, no loss or duplication.
- Assert reset mid-stream with 2 beats buffered -> out_valid=0 and counters 0 immediately (asynchronous); in_ready=1 after the first post-release edge.
- Randomized round-trip over all 6 legal formats against the extender -> every recovered immediate matches, and err_count equals the number of illegal stimuli.
